// File: rtl/fetch.sv
// fetch: instruction-fetch stage; owns the PC, issues single-outstanding imem requests,
// buffers one response while decode stalls and redirects on flush.
module fetch #(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0,
    parameter logic [XLEN-1:0] NOP_INST = 32'h0000_0013
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_stall,
    input  logic            i_flush,
    input  logic [XLEN-1:0] i_flush_pc,
    output logic            o_imem_req,
    output logic [XLEN-1:0] o_imem_addr,
    input  logic            i_imem_ack,
    input  logic [XLEN-1:0] i_imem_data,
    output logic [XLEN-1:0] or_inst,
    output logic [XLEN-1:0] or_pc,
    output logic            or_valid
);
    localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, HOLD = 2'd2, DISCARD = 2'd3;

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] pc_q, pc_d, req_addr_q, req_addr_d;
    logic [XLEN-1:0] hold_inst_q, hold_inst_d, hold_pc_q, hold_pc_d;
    logic [XLEN-1:0] inst_q, inst_d, opc_q, opc_d;
    logic            req_q, req_d, valid_q, valid_d;

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        hold_inst_d = hold_inst_q;
        hold_pc_d   = hold_pc_q;
        inst_d      = inst_q;
        opc_d       = opc_q;
        valid_d     = valid_q;
        if (state_q == IDLE) begin
            state_d = FETCH;
        end else if (i_flush) begin
            pc_d        = i_flush_pc & ~XLEN'(3);
            inst_d      = NOP_INST;
            valid_d     = 1'b0;
            hold_inst_d = NOP_INST;
            hold_pc_d   = '0;
            state_d     = (req_q && !i_imem_ack) ? DISCARD : FETCH;
        end else if (state_q == FETCH && i_imem_ack) begin
            pc_d        = pc_q + XLEN'(4);
            hold_inst_d = i_stall ? i_imem_data : hold_inst_q;
            hold_pc_d   = i_stall ? pc_q : hold_pc_q;
            inst_d      = i_stall ? inst_q : i_imem_data;
            opc_d       = i_stall ? opc_q : pc_q;
            valid_d     = i_stall ? valid_q : 1'b1;
            state_d     = i_stall ? HOLD : FETCH;
        end else if (state_q == HOLD && !i_stall) begin
            inst_d  = hold_inst_q;
            opc_d   = hold_pc_q;
            valid_d = 1'b1;
            state_d = FETCH;
        end else if (state_q == DISCARD && i_imem_ack) begin
            state_d = FETCH;
        end
        req_d      = (state_d == FETCH) || (state_d == DISCARD);
        // the address of an unacknowledged request must not move, even when pc is redirected
        req_addr_d = (state_d == DISCARD) ? req_addr_q : pc_d;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q     <= IDLE;
            pc_q        <= RESET_PC;
            req_addr_q  <= RESET_PC;
            req_q       <= 1'b0;
            hold_inst_q <= NOP_INST;
            hold_pc_q   <= '0;
            inst_q      <= NOP_INST;
            opc_q       <= '0;
            valid_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            req_addr_q  <= req_addr_d;
            req_q       <= req_d;
            hold_inst_q <= hold_inst_d;
            hold_pc_q   <= hold_pc_d;
            inst_q      <= inst_d;
            opc_q       <= opc_d;
            valid_q     <= valid_d;
        end
    end

    assign o_imem_req  = req_q;
    assign o_imem_addr = req_addr_q;
    assign or_inst     = inst_q;
    assign or_pc       = opc_q;
    assign or_valid    = valid_q;
endmodule

// File: doc/fetch.md
# fetch

Instruction-fetch stage of the RV32I_Zicsr pipeline. It sits directly upstream of the decode stage. It owns the program counter and issues single-outstanding requests to instruction memory over a req/ack handshake. Each fetched word and its PC are presented to decode in registered outputs. A one-entry hold buffer absorbs a response that returns while decode is stalled, and a flush with a redirect target drops or discards in-flight work and restarts fetch at the target.

## Interface
- `XLEN`, 32, data/address width (from `header.vh`)
- `RESET_PC`, 32'h0000_0000, first fetch address after reset
- `NOP_INST`, 32'h0000_0013, bubble instruction (`addi x0,x0,0`)

- `i_clk`  in  1  CPU clock
- `i_rst_n`  in  1  reset, asynchronous, active-low
- `i_stall`  in  1  decode cannot accept; hold outputs
- `i_flush`  in  1  redirect request (branch/jump/trap), synchronous
- `i_flush_pc`  in  XLEN  redirect target; bits [1:0] ignored (forced 0)
- `o_imem_req`  out  1  fetch request valid (registered)
- `o_imem_addr`  out  XLEN  fetch address, word aligned
- `i_imem_ack`  in  1  response valid; may assert the same cycle as req
- `i_imem_data`  in  XLEN  instruction word, valid with ack
- `or_inst`  out  XLEN  instruction to decode
- `or_pc`  out  XLEN  PC of `or_inst`
- `or_valid`  out  1  `or_inst` is a real instruction (0 means bubble)

## Operation
- Registers:
  - `pc`: next fetch address.
  - Hold buffer: `hold_inst`, `hold_pc`.
  - FSM states: IDLE, FETCH, HOLD, DISCARD.
- `o_imem_req` = 1 in FETCH and DISCARD. `o_imem_addr` = `pc`, stable until ack.
- **IDLE**: entered only from reset. Next edge goes to FETCH.
- **FETCH**, on ack:
  - Stall low: `or_inst`←data, `or_pc`←`pc`, `or_valid`←1, `pc`←`pc`+4. Remain in FETCH with req high (back-to-back).
  - Stall high: `hold_inst`←data, `hold_pc`←`pc`, `pc`←`pc`+4, go to HOLD. Outputs unchanged.
- **FETCH**, no ack, stall high: outputs hold and the request stays pending.
- **HOLD**: req low.
  - When stall is low at an edge: outputs←hold buffer, `or_valid`←1, go to FETCH.
  - While stall is high: outputs hold.
- **Flush** (priority over stall, any non-IDLE state):
  - Always: `pc`←{`i_flush_pc`[31:2],2'b00}, `or_inst`←`NOP_INST`, `or_valid`←0, hold buffer invalidated.
  - Request outstanding and no ack this cycle: go to DISCARD.
  - Otherwise: go to FETCH.
- **DISCARD**: req stays high on the *old* address, because the handshake forbids changing the address before ack. This conflicts with `o_imem_addr`=`pc`, so the old address is kept in a separate `req_addr` register, and `o_imem_addr` = `req_addr` in all states. On ack, data is dropped and the FSM goes to FETCH with `req_addr`←`pc`. A further flush in DISCARD updates `pc` only.
- `pc` arithmetic is modulo 2^32: 32'hFFFF_FFFC + 4 = 0.
- The stall input from decode while `or_valid`=0 still holds outputs; no bubbles are inserted by fetch except on flush.

## Timing
- Reset values:
  - FSM = IDLE, `pc`=`req_addr`=`RESET_PC`, `o_imem_req`=0
  - `or_inst`=`NOP_INST`, `or_pc`=0, `or_valid`=0, hold buffer cleared
- First request: `o_imem_req`=1 in the cycle after the first edge following reset deassert.
- Latency: an ack sampled at edge N appears on `or_*` after edge N.
- Zero-wait memory (ack in the same cycle as req) gives 1 instruction per cycle.
- Flush sampled at edge N: `or_valid`=0 after N. With no outstanding request, the target address is driven after N.
- Simultaneous ack+flush: data is dropped and the target is fetched next.
- Simultaneous ack+stall+flush: flush wins.
- Reset asserted mid-request: everything returns to reset values immediately. The memory must abandon the request.

## Test plan
- Reset release, zero-wait memory returning `pc`-tagged words → `or_pc` = 0,4,8,12 on consecutive cycles, `or_valid`=1 from the 2nd edge after release.
- Stall 3 cycles while ack returns word 32'h00A00093 at pc 8 → outputs hold pc 4's word. One edge after stall falls, `or_pc`=8 and `or_inst`=32'h00A00093. Next request addr = 12.
- Memory with 3-cycle ack latency, flush to 32'h0000_0100 in wait cycle 1 → `o_imem_addr` holds the old addr until ack. The response is not presented, `or_valid`=0, then a request to 0x100 is issued and `or_pc`=0x100.
- Flush to 32'h0000_0203 → fetch addr 0x200. Flush and stall in the same cycle → `or_valid`=0 and `pc`=target.
- `RESET_PC`=32'hFFFF_FFFC → second fetch addr = 0.
- Reset asserted while in HOLD → all outputs reach reset values before the next clock edge, then normal fetch restarts from `RESET_PC`.
